rgb_match_logger: RTL
=====================

# rgb_match_logger

Downstream consumer of the RGB non-overlapping sequence detector. It captures every detection pulse together with the closing colour code and a free-running cycle timestamp, and queues these events in a small first-word-fall-through FIFO. Software or a host interface drains the FIFO through a valid/ready read port. The block also keeps a saturating total-detection count and a sticky overflow flag.

## Interface
- `TS_W`, default 16: timestamp width. Timestamp counter wraps modulo 2^TS_W.
- `DEPTH`, default 8: FIFO entries. Must be a power of 2, ≥2.
- `CNT_W`, default 16: width of the total-detection counter.
- Clock and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `match`  in  1  detector output (Mealy); sampled at the rising edge.
- `last_code`  in  2  colour code presented to the detector in the same cycle as `match`.
- `rd_ready`  in  1  consumer accepts the head entry.
- `clr_ovf`  in  1  clears `overflow`.
- `rd_valid`  out  1  FIFO non-empty; head entry is presented.
- `rd_ts`  out  TS_W  timestamp of the head entry; 0 when `rd_valid`=0.
- `rd_code`  out  2  closing colour of the head entry; 0 when `rd_valid`=0.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `total`  out  CNT_W  detections seen since reset, saturating.
- `overflow`  out  1  sticky; set when a detection is dropped.

## Operation
- Reset values:
  - `rd_valid`=0, `rd_ts`=0, `rd_code`=0, `level`=0, `total`=0, `overflow`=0.
  - Internal timestamp `ts`=0; FIFO pointers = 0.
- Timestamp: `ts` increments every non-reset cycle. It wraps from 2^TS_W−1 to 0.
- Push: at an edge with `match`=1, the entry {`last_code`, `ts`} is written. `ts` is the register value before that edge's increment.
- `last_code` is stored unchecked. Code 11 is stored as-is, with no error flag.
- Pop: at an edge with `rd_valid`=1 and `rd_ready`=1, the head entry is retired. `rd_ready` while empty has no effect.
- Full without pop: a push is dropped and `overflow` is set. FIFO contents and `level` are unchanged.
- Full with pop in the same edge: the push is accepted and `level` stays at DEPTH.
- Empty, push and pop in the same edge: no pop occurs, because `rd_valid` was 0. The push lands and `level` becomes 1.
- `total`:
  - Increments on every `match`=1 edge, including dropped pushes.
  - Holds at 2^CNT_W−1.
- `clr_ovf`: clears `overflow` at the edge. If a drop occurs at the same edge, set wins.
- `rst` mid-operation: all state returns to reset values at that edge. Queued entries are discarded.

## Timing
- Push-to-visible latency is 1 cycle. For `match` at edge k into an empty FIFO, `rd_valid`=1 and the head fields are valid from just after edge k.
- `rd_ts`/`rd_code` are combinational from the head slot, gated by `rd_valid`. They are stable while `rd_valid`=1 and `rd_ready`=0.
- After a pop at edge k, the next entry (if any) is presented just after edge k.
- `level`, `total` and `overflow` are registered and update at the edge of the causing event.
- No combinational path from `match` or `last_code` to any output.

## Structure
- Shared package `rgb_pkg`:
  - Colour code width (2).
  - Constants CODE_G=2'b00, CODE_B=2'b01, CODE_R=2'b10.
  - An event struct {code, ts} parameterised through a localparam width.
  - The detector and this block both import it.
- Sub-module `rgb_evt_fifo`: a generic synchronous FWFT FIFO (width and depth parameters; push, pop, full, empty, level).
- The top level holds the timestamp counter, total counter, overflow flag and output gating.

## Test plan
- Basic push: after reset, pulse `match`=1 with `last_code`=01 when `ts`=5 → `rd_valid`=1, `rd_ts`=5, `rd_code`=01, `level`=1, `total`=1.
- Overflow: hold `rd_ready`=0 and give 9 matches → `level`=8, `total`=9, `overflow`=1. Draining returns the first 8 entries in order.
- Full with simultaneous push and pop: push and pop at the same edge → `level` stays 8, `overflow`=0, new entry is last out.
- Timestamp wrap: matches at `ts`=65535 and the next cycle → entries read 65535 then 0.
- Overflow clear: `clr_ovf` together with a drop → `overflow` stays 1. `clr_ovf` alone next cycle → `overflow`=0.
- Reset mid-run: assert `rst` with `level`=3 and `total`=3 → next cycle all outputs 0, and the next match gives `rd_ts`=0 if it arrives in the first post-reset cycle.

Source files
------------

// File: rtl/rgb_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB sequence detector and its match logger.
// Holds the colour code width, the named colour codes and the logged event
// record layout. No ports; this is a package.
// ---------------------------------------------------------------------------
package rgb_pkg;

    // Width of one colour code as seen by the detector and logger
    localparam int CODE_W = 2;

    // Named colour codes; code 2'b11 has no name and is carried through untouched
    localparam logic [CODE_W-1:0] CODE_G = 2'b00;
    localparam logic [CODE_W-1:0] CODE_B = 2'b01;
    localparam logic [CODE_W-1:0] CODE_R = 2'b10;

    // Timestamp width of the event record at the default logger configuration
    localparam int EVT_TS_W = 16;

    // One logged detection: closing colour in the upper bits, timestamp below
    typedef struct packed {
        logic [CODE_W-1:0]   code;
        logic [EVT_TS_W-1:0] ts;
    } rgb_evt_t;

endpackage

// File: rtl/rgb_match_logger_if.sv
// ---------------------------------------------------------------------------
// rgb_match_logger_if
// Bundles the detector-facing inputs and the host-facing read port of the
// match logger.
//   match, last_code   : detector pulse and the colour that closed it
//   rd_ready           : consumer accepts the head entry
//   clr_ovf            : clears the sticky overflow flag
//   rd_valid/rd_ts/rd_code : head entry of the event FIFO (zero when empty)
//   level, total, overflow : FIFO occupancy, saturating count, sticky drop flag
// Modports: master drives the inputs (host/detector side), slave is the logger.
// ---------------------------------------------------------------------------
interface rgb_match_logger_if
    import rgb_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              match;
    logic [CODE_W-1:0] last_code;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [TS_W-1:0]   rd_ts;
    logic [CODE_W-1:0] rd_code;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  total;
    logic              overflow;

    modport master (
        output match, last_code, rd_ready, clr_ovf,
        input  rd_valid, rd_ts, rd_code, level, total, overflow
    );

    modport slave (
        input  match, last_code, rd_ready, clr_ovf,
        output rd_valid, rd_ts, rd_code, level, total, overflow
    );

endinterface

// File: rtl/rgb_evt_fifo.sv
// ---------------------------------------------------------------------------
// rgb_evt_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is
// presented combinationally on o_popData whenever o_empty is low.
//   clk, rst     : clock and synchronous active-high reset
//   i_push       : write i_pushData this edge (ignored when full unless popping)
//   i_pushData   : entry to write
//   i_pop        : retire the head entry this edge (ignored when empty)
//   o_popData    : head entry (undefined contents when empty)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
//   o_level      : current entry count, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module rgb_evt_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_popData,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             w_pop;
    logic             w_push;

    // A pop only happens when something is there; a push into a full FIFO is
    // allowed only when the head leaves at the same edge, freeing its slot.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the
    // level unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: stale slots are never presented because the
    // empty flag gates the head downstream.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_popData = r_mem[r_rdPtr];
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;

endmodule

// File: rtl/rgb_match_logger.sv
// ---------------------------------------------------------------------------
// rgb_match_logger
// Captures each detector match with its closing colour and a free-running
// timestamp into a FWFT event FIFO that a host drains through a valid/ready
// port. Also keeps a saturating detection count and a sticky overflow flag.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : rgb_match_logger_if slave modport (match/last_code in, read port,
//          level/total/overflow status out)
// ---------------------------------------------------------------------------
module rgb_match_logger
    import rgb_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    rgb_match_logger_if.slave bus
);
    localparam int EVT_W = CODE_W + TS_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_total;
    logic             r_overflow;

    logic [EVT_W-1:0] w_pushData;
    logic [EVT_W-1:0] w_headData;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_rdValid;
    logic             w_pop;
    logic             w_drop;

    // Entry layout matches rgb_evt_t: code on top, timestamp below. The
    // timestamp is the value held before this edge's increment.
    assign w_pushData = {bus.last_code, r_ts};

    // When full, the only way a match gets in is if the head leaves at the
    // same edge; otherwise the detection is lost.
    assign w_rdValid = !w_empty;
    assign w_pop     = bus.rd_ready && w_rdValid;
    assign w_drop    = bus.match && w_full && !w_pop;

    rgb_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (bus.match),
        .i_pushData (w_pushData),
        .i_pop      (bus.rd_ready),
        .o_popData  (w_headData),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + TS_W'(1);
    end

    // Counts every match, dropped or not, and parks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
        end else if (bus.match && (r_total != {CNT_W{1'b1}})) begin
            r_total <= r_total + CNT_W'(1);
        end
    end

    // Sticky drop flag; a drop at the same edge as a clear keeps it set so
    // the host never misses a loss it has not yet seen.
    always_ff @(posedge clk) begin
        if (rst)           r_overflow <= 1'b0;
        else if (w_drop)   r_overflow <= 1'b1;
        else if (bus.clr_ovf) r_overflow <= 1'b0;
    end

    // Head fields read as zero while the FIFO is empty.
    assign bus.rd_valid = w_rdValid;
    assign bus.rd_ts    = w_rdValid ? w_headData[TS_W-1:0] : '0;
    assign bus.rd_code  = w_rdValid ? w_headData[EVT_W-1:TS_W] : '0;
    assign bus.level    = w_level;
    assign bus.total    = r_total;
    assign bus.overflow = r_overflow;

endmodule
